// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage owning the PC, the imem req/ack handshake and the IF/ID register
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_en,
    input  logic        if_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        if_valid,
    output logic        fetch_stall
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcid_q, pcid_d;
    logic        valid_q, valid_d;
    logic        load;
    logic [31:0] load_inst;
    logic [31:0] tgt;
    logic [31:0] seq;

    assign tgt         = redirect_pc & ~32'h3;
    assign seq         = addr_q + 32'd4;
    assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr   = addr_q;
    assign fetch_stall = imem_req & ~imem_ack;
    assign inst_id     = inst_q;
    assign pc_id       = pcid_q;
    assign if_valid    = valid_q;

    // Next-state: fetch FSM, PC/address update and IF/ID load; the address only moves once the handshake completes
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        inst_d    = inst_q;
        pcid_d    = pcid_q;
        valid_d   = valid_q;
        load      = 1'b0;
        load_inst = imem_rdata;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                pc_d    = redirect_valid ? tgt : pc_q;
                addr_d  = redirect_valid ? tgt : pc_q;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    addr_d  = imem_ack ? tgt : addr_q;
                    state_d = imem_ack ? FETCH : DISCARD;
                end else if (imem_ack && if_en) begin
                    load   = 1'b1;
                    pc_d   = seq;
                    addr_d = seq;
                end else if (imem_ack) begin
                    hold_d  = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    addr_d  = tgt;
                    state_d = FETCH;
                end else if (if_en) begin
                    load      = 1'b1;
                    load_inst = hold_q;
                    pc_d      = seq;
                    addr_d    = seq;
                    state_d   = FETCH;
                end
            end
            DISCARD: begin
                pc_d = redirect_valid ? tgt : pc_q;
                if (imem_ack) begin
                    addr_d  = pc_d;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (if_rst) begin
            inst_d  = INST_NOP;
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = load_inst;
            pcid_d  = seq;
            valid_d = 1'b1;
        end
    end

    // State register; asynchronous reset aborts any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            addr_q  <= PC_RESET;
            hold_q  <= INST_NOP;
            inst_q  <= INST_NOP;
            pcid_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            inst_q  <= inst_d;
            pcid_q  <= pcid_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven directed check of the fetch stage against hand-computed expectations
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_en = 1'b1;
    logic        if_rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        if_valid;
    logic        fetch_stall;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        en, rs, rv;
        logic [31:0] rpc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic [31:0] e_inst, e_pcid;
        logic        e_valid;
    } vec_t;

    vec_t tbl[29];

    always #5 clk = ~clk;

    // memory content: each word holds its address plus a tag
    assign imem_rdata = imem_addr + 32'h1000_0000;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .if_en(if_en), .if_rst(if_rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_id(inst_id), .pc_id(pc_id),
        .if_valid(if_valid), .fetch_stall(fetch_stall)
    );

    function automatic logic [31:0] m(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    function automatic vec_t mk(input logic en, rs, rv, input logic [31:0] rpc, input logic ack,
                                input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                                input logic [31:0] e_inst, e_pcid, input logic e_valid);
        vec_t v;
        v.en = en; v.rs = rs; v.rv = rv; v.rpc = rpc; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
        v.e_inst = e_inst; v.e_pcid = e_pcid; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,1,            0,32'h0,0,          32'h0,32'h0,1'b0);
        tbl[1]  = mk(1,0,0,0,1,            1,32'h0,0,          m(32'h0),32'h4,1);
        tbl[2]  = mk(1,0,0,0,1,            1,32'h4,0,          m(32'h4),32'h8,1);
        tbl[3]  = mk(1,0,0,0,1,            1,32'h8,0,          m(32'h8),32'hC,1);
        tbl[4]  = mk(1,0,0,0,0,            1,32'hC,1,          m(32'h8),32'hC,1);
        tbl[5]  = mk(1,0,0,0,0,            1,32'hC,1,          m(32'h8),32'hC,1);
        tbl[6]  = mk(1,0,0,0,1,            1,32'hC,0,          m(32'hC),32'h10,1);
        tbl[7]  = mk(0,0,0,0,1,            1,32'h10,0,         m(32'hC),32'h10,1);
        tbl[8]  = mk(0,0,0,0,0,            0,32'h10,0,         m(32'hC),32'h10,1);
        tbl[9]  = mk(0,0,0,0,0,            0,32'h10,0,         m(32'hC),32'h10,1);
        tbl[10] = mk(1,0,0,0,0,            0,32'h10,0,         m(32'h10),32'h14,1);
        tbl[11] = mk(1,0,0,0,1,            1,32'h14,0,         m(32'h14),32'h18,1);
        tbl[12] = mk(1,0,0,0,1,            1,32'h18,0,         m(32'h18),32'h1C,1);
        tbl[13] = mk(1,0,0,0,1,            1,32'h1C,0,         m(32'h1C),32'h20,1);
        tbl[14] = mk(1,0,1,32'h103,0,      1,32'h20,1,         m(32'h1C),32'h20,1);
        tbl[15] = mk(1,0,0,0,0,            1,32'h20,1,         m(32'h1C),32'h20,1);
        tbl[16] = mk(1,0,0,0,1,            1,32'h20,0,         m(32'h1C),32'h20,1);
        tbl[17] = mk(1,0,0,0,1,            1,32'h100,0,        m(32'h100),32'h104,1);
        tbl[18] = mk(1,0,1,32'hFFFF_FFFE,1,1,32'h104,0,        m(32'h100),32'h104,1);
        tbl[19] = mk(1,0,0,0,1,            1,32'hFFFF_FFFC,0,  m(32'hFFFF_FFFC),32'h0,1);
        tbl[20] = mk(1,1,0,0,1,            1,32'h0,0,          32'h0,32'h0,0);
        tbl[21] = mk(1,0,0,0,1,            1,32'h4,0,          m(32'h4),32'h8,1);
        tbl[22] = mk(0,0,0,0,1,            1,32'h8,0,          m(32'h4),32'h8,1);
        tbl[23] = mk(1,0,1,32'h200,0,      0,32'h8,0,          m(32'h4),32'h8,1);
        tbl[24] = mk(1,0,0,0,1,            1,32'h200,0,        m(32'h200),32'h204,1);
        tbl[25] = mk(1,0,1,32'h300,0,      1,32'h204,1,        m(32'h200),32'h204,1);
        tbl[26] = mk(1,0,1,32'h400,0,      1,32'h204,1,        m(32'h200),32'h204,1);
        tbl[27] = mk(1,0,0,0,1,            1,32'h204,0,        m(32'h200),32'h204,1);
        tbl[28] = mk(1,0,0,0,1,            1,32'h400,0,        m(32'h400),32'h404,1);

        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst_id, 32'h0);
        chk("rst_pcid", pc_id, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_stall", {31'h0, fetch_stall}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            if_en = tbl[i].en; if_rst = tbl[i].rs;
            redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            imem_ack = tbl[i].ack;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_stall", i), {31'h0, fetch_stall}, {31'h0, tbl[i].e_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_inst", i), inst_id, tbl[i].e_inst);
            chk($sformatf("v%0d_pcid", i), pc_id, tbl[i].e_pcid);
            chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
            @(negedge clk);
        end

        if_en = 1'b1; if_rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_inst", inst_id, 32'h0);
        chk("arst_pcid", pc_id, 32'h0);
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_stall", {31'h0, fetch_stall}, 32'h1);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        chk("restart_inst", inst_id, m(32'h0));
        chk("restart_addr4", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
